// File: rtl/sync_lock_pkg.sv
// Shared types and default words for the deserialiser sync/lock monitor.
package sync_lock_pkg;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    WAIT_TAIL = 2'd1,
    WAIT_LOCK = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  localparam logic [9:0] DEF_SYNC_WORD = 10'b0000011111;
  localparam logic [9:0] DEF_TAIL_WORD = 10'b1001111100;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority) and async active-low reset.
module sync_sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sync_lock_monitor.sv
// Deserialiser sync/lock monitor: acquires lock, times out stalled acquisition, drops on loss.
// Optional SYNC_STATS_EN adds the relock_cnt loss-event counter port.
module sync_lock_monitor
  import sync_lock_pkg::*;
#(
  parameter int            DW          = 10,
  parameter logic [DW-1:0] SYNC_WORD   = DW'(DEF_SYNC_WORD),
  parameter logic [DW-1:0] TAIL_WORD   = DW'(DEF_TAIL_WORD),
  parameter int            SYNC_CNT    = 30,
  parameter int            ACQ_TIMEOUT = 1023,
  parameter int            LOS_CNT     = 4
) (
  input  logic          UpSig_RClk,
  input  logic          nRst,
  input  logic [DW-1:0] UpSig_ROut,
  input  logic          UpSig_nLock,
  output logic          sync_success,
  output logic [1:0]    sync_state,
  output logic          acq_timeout,
  output logic          loss_pulse
`ifdef SYNC_STATS_EN
  ,
  output logic [15:0]   relock_cnt
`endif
);

  localparam int RUN_W = cnt_width(SYNC_CNT);
  localparam int TMR_W = cnt_width(ACQ_TIMEOUT);
  localparam int LOS_W = cnt_width(LOS_CNT);

  state_t           state, state_nxt;
  logic [RUN_W-1:0] run_cnt;
  logic [TMR_W-1:0] tmr;
  logic [LOS_W-1:0] los_cnt;
  logic             is_sync, is_tail, in_wait, tmr_expire, los_last;
  logic             run_inc, tmr_clr, los_inc;
  logic             timeout_evt, loss_evt;

  assign is_sync    = (UpSig_ROut == SYNC_WORD);
  assign is_tail    = (UpSig_ROut == TAIL_WORD);
  assign in_wait    = (state == WAIT_TAIL) || (state == WAIT_LOCK);
  assign tmr_expire = (tmr == TMR_W'(ACQ_TIMEOUT - 1));
  assign los_last   = (los_cnt == LOS_W'(LOS_CNT - 1));

  assign run_inc = (state == HUNT) && is_sync;
  assign tmr_clr = !in_wait || (state_nxt != state);
  assign los_inc = (state == LOCKED) && UpSig_nLock;

  sync_sat_counter #(.WIDTH(RUN_W), .MAX(SYNC_CNT)) u_run_cnt (
    .clk(UpSig_RClk), .rst_n(nRst), .inc(run_inc), .clr(!run_inc), .cnt(run_cnt)
  );

  sync_sat_counter #(.WIDTH(TMR_W), .MAX(ACQ_TIMEOUT)) u_tmr (
    .clk(UpSig_RClk), .rst_n(nRst), .inc(in_wait), .clr(tmr_clr), .cnt(tmr)
  );

  sync_sat_counter #(.WIDTH(LOS_W), .MAX(LOS_CNT)) u_los_cnt (
    .clk(UpSig_RClk), .rst_n(nRst), .inc(los_inc), .clr(!los_inc), .cnt(los_cnt)
  );

  always_ff @(posedge UpSig_RClk or negedge nRst) begin
    if (!nRst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Advance takes priority over the timeout check when both hold in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:      if (run_cnt == RUN_W'(SYNC_CNT)) state_nxt = WAIT_TAIL;
      WAIT_TAIL: if (is_tail) state_nxt = WAIT_LOCK;
                 else if (tmr_expire) state_nxt = HUNT;
      WAIT_LOCK: if (!UpSig_nLock) state_nxt = LOCKED;
                 else if (tmr_expire) state_nxt = HUNT;
      LOCKED:    if (los_last && UpSig_nLock) state_nxt = HUNT;
      default:   state_nxt = HUNT;
    endcase
  end

  always_comb begin
    timeout_evt = in_wait && (state_nxt == HUNT);
    loss_evt    = (state == LOCKED) && (state_nxt == HUNT);
  end

  always_ff @(posedge UpSig_RClk or negedge nRst) begin
    if (!nRst) begin
      sync_success <= 1'b0;
      acq_timeout  <= 1'b0;
      loss_pulse   <= 1'b0;
    end else begin
      sync_success <= (state == LOCKED);
      acq_timeout  <= timeout_evt;
      loss_pulse   <= loss_evt;
    end
  end

  assign sync_state = state;

`ifdef SYNC_STATS_EN
  sync_sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_relock_cnt (
    .clk(UpSig_RClk), .rst_n(nRst), .inc(loss_evt), .clr(1'b0), .cnt(relock_cnt)
  );
`endif

endmodule

// File: tb/tb_sync_lock_monitor.sv
// Self-checking bench for sync_lock_monitor: directed scenarios plus randomized traffic vs a reference model.
module tb_sync_lock_monitor;

  localparam logic [9:0] SYNC = 10'b0000011111;
  localparam logic [9:0] TAIL = 10'b1001111100;
  localparam int N_SYNC = 30;
  localparam int N_ACQ  = 1023;
  localparam int N_LOS  = 4;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [9:0] word = '0;
  logic       nlock = 1'b1;
  logic       sync_success, acq_timeout, loss_pulse;
  logic [1:0] sync_state;
`ifdef SYNC_STATS_EN
  logic [15:0] relock_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: spec rules in plain integers.
  int m_state, m_succ, m_to, m_loss, m_run, m_tmr, m_los, m_relock;

  sync_lock_monitor dut (
    .UpSig_RClk  (clk),
    .nRst        (nrst),
    .UpSig_ROut  (word),
    .UpSig_nLock (nlock),
    .sync_success(sync_success),
    .sync_state  (sync_state),
    .acq_timeout (acq_timeout),
    .loss_pulse  (loss_pulse)
`ifdef SYNC_STATS_EN
    ,
    .relock_cnt  (relock_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_succ = 0; m_to = 0; m_loss = 0;
    m_run = 0; m_tmr = 0; m_los = 0; m_relock = 0;
  endtask

  task automatic model_edge(input logic [9:0] w, input logic n);
    int nxt, to, ls;
    nxt = m_state; to = 0; ls = 0;
    if (m_state == 0 && m_run == N_SYNC) nxt = 1;
    else if (m_state == 1 && w == TAIL) nxt = 2;
    else if (m_state == 2 && !n) nxt = 3;
    else if ((m_state == 1 || m_state == 2) && m_tmr == N_ACQ - 1) begin nxt = 0; to = 1; end
    else if (m_state == 3 && n && m_los == N_LOS - 1) begin nxt = 0; ls = 1; end
    m_run  = (m_state == 0 && w == SYNC) ? ((m_run < N_SYNC) ? m_run + 1 : N_SYNC) : 0;
    m_tmr  = ((m_state == 1 || m_state == 2) && nxt == m_state) ? m_tmr + 1 : 0;
    m_los  = (m_state == 3 && n) ? m_los + 1 : 0;
    m_succ = (m_state == 3) ? 1 : 0;
    if (ls && m_relock < 65535) m_relock++;
    m_to = to; m_loss = ls; m_state = nxt;
  endtask

  task automatic check_all();
    chk("state", 32'(sync_state), 32'(m_state));
    chk("sync_success", 32'(sync_success), 32'(m_succ));
    chk("acq_timeout", 32'(acq_timeout), 32'(m_to));
    chk("loss_pulse", 32'(loss_pulse), 32'(m_loss));
`ifdef SYNC_STATS_EN
    chk("relock_cnt", 32'(relock_cnt), 32'(m_relock));
`endif
  endtask

  task automatic step(input logic [9:0] w, input logic n);
    word = w; nlock = n;
    @(posedge clk);
    if (nrst) model_edge(w, n); else model_reset();
    #1;
    check_all();
  endtask

  task automatic send_syncs(input int cnt);
    for (int i = 0; i < cnt; i++) step(SYNC, 1'b1);
  endtask

  // From HUNT with run_cnt 0: full run, then tail, ending in WAIT_LOCK.
  task automatic go_wait_lock();
    send_syncs(N_SYNC);
    step(10'h000, 1'b1);
    chk("enter_wait_tail", 32'(sync_state), 32'd1);
    step(TAIL, 1'b1);
    chk("enter_wait_lock", 32'(sync_state), 32'd2);
  endtask

  task automatic go_locked();
    go_wait_lock();
    step(SYNC, 1'b0);
    chk("enter_locked", 32'(sync_state), 32'd3);
    chk("success_lag", 32'(sync_success), 32'd0);
    step(SYNC, 1'b0);
    chk("success_high", 32'(sync_success), 32'd1);
  endtask

  task automatic lose_lock();
    for (int i = 0; i < N_LOS - 1; i++) step(10'h155, 1'b1);
    step(10'h155, 1'b1);
    chk("loss_pulse_edge", 32'(loss_pulse), 32'd1);
    chk("loss_to_hunt", 32'(sync_state), 32'd0);
    step(10'h000, 1'b1);
    chk("loss_success_drop", 32'(sync_success), 32'd0);
    chk("loss_pulse_one", 32'(loss_pulse), 32'd0);
  endtask

  initial begin
    int k;
    logic [9:0] w;
    model_reset();
    #12;
    chk("rst_state", 32'(sync_state), 32'd0);
    chk("rst_success", 32'(sync_success), 32'd0);
    chk("rst_timeout", 32'(acq_timeout), 32'd0);
    chk("rst_loss", 32'(loss_pulse), 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // 30 syncs: still HUNT after the 30th edge, WAIT_TAIL one edge later.
    send_syncs(N_SYNC);
    chk("hunt_after_30", 32'(sync_state), 32'd0);
    step(TAIL, 1'b1);
    chk("wait_tail_after_31", 32'(sync_state), 32'd1);
    step(TAIL, 1'b1);
    chk("wait_lock", 32'(sync_state), 32'd2);
    step(SYNC, 1'b0);
    chk("locked", 32'(sync_state), 32'd3);
    step(SYNC, 1'b0);
    chk("success", 32'(sync_success), 32'd1);

    // Three nLock-high cycles are tolerated, the fourth declares loss.
    for (int i = 0; i < 3; i++) step(SYNC, 1'b1);
    step(SYNC, 1'b0);
    chk("los3_stays_locked", 32'(sync_state), 32'd3);
    lose_lock();

    // Broken run restarts counting.
    send_syncs(29);
    step(10'h000, 1'b1);
    for (int i = 0; i < N_SYNC; i++) begin
      step(SYNC, 1'b1);
      chk("run_break_hunt", 32'(sync_state), 32'd0);
    end
    step(SYNC, 1'b1);
    chk("run2_wait_tail", 32'(sync_state), 32'd1);

    // No tail: timeout after exactly ACQ_TIMEOUT cycles in WAIT_TAIL.
    k = 0;
    while (k < N_ACQ + 20) begin
      k++;
      step(SYNC, 1'b0);
      if (acq_timeout) break;
    end
    chk("timeout_cycles", 32'(k), 32'(N_ACQ));
    chk("timeout_hunt", 32'(sync_state), 32'd0);
    chk("timeout_success", 32'(sync_success), 32'd0);
    step(10'h000, 1'b1);
    chk("timeout_one_cycle", 32'(acq_timeout), 32'd0);

    // Asynchronous reset in WAIT_LOCK.
    go_wait_lock();
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_state", 32'(sync_state), 32'd0);
    chk("async_rst_success", 32'(sync_success), 32'd0);
    chk("async_rst_timeout", 32'(acq_timeout), 32'd0);
    chk("async_rst_loss", 32'(loss_pulse), 32'd0);
    model_reset();
    step(SYNC, 1'b1);
    step(SYNC, 1'b1);
    @(negedge clk);
    nrst = 1'b1;

    // Re-acquire and two lock/loss rounds.
    go_locked();
    lose_lock();
    go_locked();
    lose_lock();
`ifdef SYNC_STATS_EN
    chk("relock_two", 32'(relock_cnt), 32'd2);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 99);
      if (k < 85) w = SYNC;
      else if (k < 93) w = TAIL;
      else w = 10'($urandom);
      step(w, ($urandom_range(0, 99) < 35));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
